// File: rtl/ecg_window_feeder.sv
// ---------------------------------------------------------------------------
// ecg_window_feeder
//
// Sliding-window feeder for the fully connected layers. Accepts the 8-bit
// signed ECG sample stream one sample per handshake and publishes a held,
// parallel window of TAPS samples. The first window appears once the window
// has filled. After that, a new window appears every STRIDE accepted samples.
// A published window stays stable until the consumer takes it. A sample that
// would publish over an unconsumed window is held off via s_ready.
//
// Parameters
//   TAPS    window length (node input count)
//   STRIDE  accepted samples between successive windows (1..TAPS)
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   s_data    signed sample
//   s_valid   sample offered
//   s_ready   sample accepted when s_valid && s_ready
//   flush     record boundary, restarts the window fill
//   win_flat  published window, tap k = win_flat[8k+7:8k], tap 0 oldest
//   w_valid   win_flat holds an unconsumed window
//   w_ready   consumer takes the window when w_valid && w_ready
//   win_cnt   windows published since reset (wraps)
//
// Configuration macro
//   FEEDER_ZERO_PAD_EN  when defined, the window counts as full from
//                       reset/flush. The first window is published after
//                       STRIDE accepts, and the older taps are zero.
// ---------------------------------------------------------------------------
module ecg_window_feeder #(
  parameter int TAPS   = 30,
  parameter int STRIDE = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                flush,
  output logic [8*TAPS-1:0]   win_flat,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [15:0]         win_cnt
);

  localparam int FW = $clog2(TAPS + 1);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [FW-1:0] FILL_FULL   = FW'(TAPS);
  localparam logic [SW-1:0] STRIDE_LAST = SW'(STRIDE - 1);

`ifdef FEEDER_ZERO_PAD_EN
  localparam logic [FW-1:0] FILL_INIT = FILL_FULL;
`else
  localparam logic [FW-1:0] FILL_INIT = '0;
`endif

  logic [7:0]        sh_q [TAPS];
  logic [7:0]        sh_d [TAPS];
  logic [7:0]        sh_shift [TAPS];
  logic [FW-1:0]     fill_q, fill_d, fill_post;
  logic [SW-1:0]     stride_q, stride_d;
  logic              first_q, first_d;
  logic [8*TAPS-1:0] win_flat_q, win_flat_d;
  logic              w_valid_q, w_valid_d;
  logic [15:0]       win_cnt_q, win_cnt_d;
  logic              due;
  logic              accept;
  logic              trigger;

  // Next-state logic. "due" describes what the next accepted sample would
  // do. It is computed from registered state only, so s_ready depends
  // combinationally on w_ready alone.
  always_comb begin
    fill_post = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;

`ifdef FEEDER_ZERO_PAD_EN
    // The window is always treated as full here, so only the stride
    // decides when a window is published, including the first one.
    due = (fill_post == FILL_FULL) && (stride_q == STRIDE_LAST);
`else
    due = (fill_post == FILL_FULL) && (first_q || (stride_q == STRIDE_LAST));
`endif

    // Hold off only the sample that would overwrite an unconsumed window.
    // If the consumer takes the window in the same cycle, the sample is
    // allowed through.
    s_ready = !(due && w_valid_q && !w_ready);
    accept  = s_valid && s_ready;
    trigger = accept && !flush && due;

    for (int k = 0; k < TAPS - 1; k++) begin
      sh_shift[k] = sh_q[k+1];
    end
    sh_shift[TAPS-1] = s_data;

    sh_d       = sh_q;
    fill_d     = fill_q;
    stride_d   = stride_q;
    first_d    = first_q;
    win_flat_d = win_flat_q;
    w_valid_d  = w_valid_q;
    win_cnt_d  = win_cnt_q;

    // A flush takes priority over a coincident accept. The handshake still
    // completes, but the sample is dropped.
    if (flush) begin
      fill_d   = FILL_INIT;
      stride_d = '0;
      first_d  = 1'b1;
      for (int k = 0; k < TAPS; k++) begin
        sh_d[k] = '0;
      end
    end else if (accept) begin
      sh_d   = sh_shift;
      fill_d = fill_post;
      if (due) begin
        stride_d = '0;
        first_d  = 1'b0;
      end else if (fill_post == FILL_FULL) begin
        stride_d = stride_q + 1'b1;
      end
    end

    // A new window beats the consume-clear, so w_valid stays high on a
    // simultaneous take-and-publish.
    if (trigger) begin
      for (int k = 0; k < TAPS; k++) begin
        win_flat_d[8*k +: 8] = sh_shift[k];
      end
      w_valid_d = 1'b1;
      win_cnt_d = win_cnt_q + 16'd1;
    end else if (w_valid_q && w_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        sh_q[k] <= '0;
      end
      fill_q     <= FILL_INIT;
      stride_q   <= '0;
      first_q    <= 1'b1;
      win_flat_q <= '0;
      w_valid_q  <= 1'b0;
      win_cnt_q  <= '0;
    end else begin
      sh_q       <= sh_d;
      fill_q     <= fill_d;
      stride_q   <= stride_d;
      first_q    <= first_d;
      win_flat_q <= win_flat_d;
      w_valid_q  <= w_valid_d;
      win_cnt_q  <= win_cnt_d;
    end
  end

  assign win_flat = win_flat_q;
  assign w_valid  = w_valid_q;
  assign win_cnt  = win_cnt_q;

endmodule
